// File: rtl/div_seq_alu.sv
// div_seq_alu: multi-cycle 32-bit divider for RV32M DIV/DIVU/REM/REMU.
// Restoring shift-subtract, one quotient bit per clock. Signed operands are
// converted to magnitudes on entry, and the signs are corrected on exit.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle request, sampled only in IDLE
//   op[1:0]      00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//   A[31:0]      dividend (sampled with start)
//   B[31:0]      divisor  (sampled with start)
//   busy         high while an operation is in flight (CALC/DONE)
//   result_valid one-cycle completion pulse
//   result[31:0] quotient or remainder, held until the next completion
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, divide-by-zero and signed overflow bypass CALC
//   (latency 1 instead of 33). The results are identical either way.
module div_seq_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [1:0]  op_r;
    logic [31:0] a_raw_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] div_r;
    logic [5:0]  cnt_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic        div0_r;
    logic        ovf_r;
    logic        busy_r;
    logic        valid_r;
    logic [31:0] result_r;

    // Two's-complement negate.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Operand decode at request time.
    logic        signed_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic        div0_s;
    logic        ovf_s;

    // Magnitude conversion and special-case detection for the incoming request.
    always_comb begin
        signed_s = (op[0] == 1'b0);
        if (signed_s && A[31]) begin
            a_mag_s = neg32(A);
        end else begin
            a_mag_s = A;
        end
        if (signed_s && B[31]) begin
            b_mag_s = neg32(B);
        end else begin
            b_mag_s = B;
        end
        div0_s = (B == 32'd0);
        ovf_s  = signed_s && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    end

    // One restoring step: the upper 33 bits of the shifted {rem, quo}
    // against the divisor. diff_s[33] is the borrow.
    logic [32:0] shift_s;
    logic [33:0] diff_s;
    logic        borrow_s;
    logic [31:0] rem_step_s;
    logic [31:0] quo_step_s;

    // Trial subtraction for the current iteration.
    always_comb begin
        shift_s  = {rem_r, quo_r[31]};
        diff_s   = {1'b0, shift_s} - {2'b00, div_r};
        borrow_s = diff_s[33];
        if (borrow_s) begin
            rem_step_s = shift_s[31:0];
        end else begin
            rem_step_s = diff_s[31:0];
        end
        quo_step_s = {quo_r[30:0], ~borrow_s};
    end

    // Final sign correction, special-case override, and quotient/remainder select.
    logic [31:0] q_fix_s;
    logic [31:0] r_fix_s;
    logic [31:0] res_sel_s;

    // Result formation while in DONE.
    always_comb begin
        if (q_neg_r) begin
            q_fix_s = neg32(quo_r);
        end else begin
            q_fix_s = quo_r;
        end
        if (r_neg_r) begin
            r_fix_s = neg32(rem_r);
        end else begin
            r_fix_s = rem_r;
        end
        if (div0_r) begin
            q_fix_s = 32'hFFFF_FFFF;
            r_fix_s = a_raw_r;
        end else if (ovf_r) begin
            q_fix_s = 32'h8000_0000;
            r_fix_s = 32'd0;
        end else begin
            q_fix_s = q_fix_s;
            r_fix_s = r_fix_s;
        end
        if (op_r[1]) begin
            res_sel_s = r_fix_s;
        end else begin
            res_sel_s = q_fix_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
`ifdef DIV_EARLY_OUT_EN
                    if (div0_s || ovf_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
`else
                    state_nxt_s = CALC;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                // The counter is decremented on this edge; the last iteration runs when it reads 1.
                if (cnt_r == 6'd1) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= 2'd0;
            a_raw_r  <= 32'd0;
            quo_r    <= 32'd0;
            rem_r    <= 32'd0;
            div_r    <= 32'd0;
            cnt_r    <= 6'd0;
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            div0_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= 32'd0;
        end else begin
            busy_r  <= (state_nxt_s != IDLE);
            valid_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        a_raw_r <= A;
                        quo_r   <= a_mag_s;
                        rem_r   <= 32'd0;
                        div_r   <= b_mag_s;
                        cnt_r   <= 6'd32;
                        q_neg_r <= (op[0] == 1'b0) && (A[31] ^ B[31]);
                        r_neg_r <= (op[0] == 1'b0) && A[31];
                        div0_r  <= div0_s;
                        ovf_r   <= ovf_s;
                    end
                end
                CALC: begin
                    quo_r <= quo_step_s;
                    rem_r <= rem_step_s;
                    cnt_r <= cnt_r - 6'd1;
                end
                DONE: begin
                    result_r <= res_sel_s;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign result_valid = valid_r;
    assign result       = result_r;

endmodule

// File: tb/tb_div_seq_alu.sv
// Directed-vector testbench for div_seq_alu. Requests push the expected result
// and its due cycle into a queue. A monitor pops one entry on every
// result_valid and checks both the value and the arrival cycle.
module tb_div_seq_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    div_seq_alu dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .A            (A),
        .B            (B),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

`ifdef DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int NORM_LAT = 33;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   valid_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after edge k, cyc == k.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor/scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                valid_count = valid_count + 1;
                checks = checks + 1;
                if (sb.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_valid: got result_valid=1 at cycle %0d, expected none (result=%h)", cyc, result);
                end else begin
                    e = sb.pop_front();
                    if (result !== e.res) begin
                        errors = errors + 1;
                        $display("FAIL %s value: got %h expected %h", e.name, result, e.res);
                    end
                    checks = checks + 1;
                    if (cyc != e.due) begin
                        errors = errors + 1;
                        $display("FAIL %s latency: got valid at cycle %0d expected cycle %0d", e.name, cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] exp, input int lat, input string name);
        exp_t e;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (push) begin
            e.res  = exp;
            e.due  = cyc + 1 + lat;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'h1234_5678;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s timeout: got %0d pending results expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
        check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name);
        issue(o, a, b, 1'b1, exp, lat, name);
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(name);
    endtask

    initial begin
        int vc;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy",   {31'd0, busy},         32'd0);
        check("reset_valid",  {31'd0, result_valid}, 32'd0);
        check("reset_result", result,                32'd0);

        run(2'd0, 32'd100,        32'd7,          32'd14,         NORM_LAT, "div_100_7");
        run(2'd2, 32'd100,        32'd7,          32'd2,          NORM_LAT, "rem_100_7");
        run(2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NORM_LAT, "div_m7_2");
        run(2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NORM_LAT, "rem_m7_2");
        run(2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  NORM_LAT, "div_7_m2");
        run(2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          NORM_LAT, "rem_7_m2");
        run(2'd1, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  NORM_LAT, "divu_big");
        run(2'd3, 32'hFFFF_FFFF,  32'h10,         32'h0000_000F,  NORM_LAT, "remu_big");
        run(2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  SPEC_LAT, "div_by0");
        run(2'd2, 32'd5,          32'd0,          32'd5,          SPEC_LAT, "rem_by0");
        run(2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  SPEC_LAT, "divu_by0");
        run(2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPEC_LAT, "div_ovf");
        run(2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPEC_LAT, "rem_ovf");

        // Start at N, ignored start at N+5, accepted start at N+34.
        issue(2'd0, 32'd9, 32'd3, 1'b1, 32'd3, NORM_LAT, "div_9_3");
        repeat (4) @(negedge clk);
        issue(2'd0, 32'd8, 32'd2, 1'b0, 32'd0, 0, "ignored");
        repeat (28) @(negedge clk);
        issue(2'd1, 32'd8, 32'd2, 1'b1, 32'd4, NORM_LAT, "divu_8_2_next");
        wait_done("back_to_back");

        // Reset mid-CALC.
        issue(2'd0, 32'd100, 32'd7, 1'b0, 32'd0, 0, "aborted");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy",   {31'd0, busy}, 32'd0);
        check("rst_mid_result", result,        32'd0);
        vc = valid_count;
        repeat (40) @(negedge clk);
        check("rst_no_valid", vc, valid_count);
        check("rst_result_hold", result, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
